// File: rtl/mfm_encoder_sync.sv
// mfm_encoder_sync
//   Write-path MFM encoder. Bytes arrive over a valid/ready handshake into a
//   one-entry holding register. At each word boundary (cnt==0 on a bit_tick)
//   the held byte is expanded into 16 MFM cells (C7 D7 .. C0 D0) and shifted
//   out MSB-first, one cell per bit_tick. Bytes flagged as sync that equal
//   A1 or C2 are replaced by the missing-clock words 0x4489 / 0x5224. If the
//   stream is active and no byte is waiting at a boundary, FILL_BYTE is
//   encoded and sent instead, and the sticky underrun flag is raised.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   enable      in   write gate; low aborts the stream and idles the encoder
//   byte_in     in   [7:0] data byte
//   byte_sync   in   byte_in is a sync mark candidate (A1/C2)
//   byte_valid  in   byte_in/byte_sync valid
//   byte_ready  out  holding register free (enable & ~hold_full)
//   bit_tick    in   one-cycle strobe per MFM cell time
//   bit_out     out  encoded cell, registered
//   bit_valid   out  one-cycle strobe, bit_out carries a new cell
//   busy        out  a word is shifting or a byte is held
//   underrun    out  sticky: a fill byte was inserted; cleared by enable low

module mfm_encoder_sync #(
  parameter logic [7:0] FILL_BYTE = 8'h4E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] byte_in,
  input  logic       byte_sync,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       bit_tick,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       busy,
  output logic       underrun
);

  localparam logic [15:0] SYNC_A1_WORD = 16'h4489;
  localparam logic [15:0] SYNC_C2_WORD = 16'h5224;
  localparam logic [7:0]  SYNC_A1_BYTE = 8'hA1;
  localparam logic [7:0]  SYNC_C2_BYTE = 8'hC2;
  localparam logic [3:0]  LAST_CELL    = 4'd15;

  // Holding register and stream state
  logic [7:0]  hold_byte_reg;
  logic        hold_sync_reg;
  logic        hold_full_reg;
  logic [15:0] shift_reg;
  logic [3:0]  cnt_reg;
  logic        active_reg;
  logic        prev_data_reg;
  logic        bit_out_reg;
  logic        bit_valid_reg;
  logic        underrun_reg;

  // Encoded candidates for the next word boundary
  logic [15:0] hold_mfm_word;
  logic [15:0] fill_mfm_word;
  logic [15:0] load_word;
  logic        transfer;
  logic        tick_en;

  assign byte_ready = enable & ~hold_full_reg;
  assign transfer   = byte_valid & byte_ready;
  assign tick_en    = bit_tick & enable;

  // MFM expansion: data cell Di = byte[i], clock cell Ci is set only when
  // both neighbouring data cells are zero. The neighbour of C7 is the last
  // data cell of the previous word (prev_data_reg).
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mfm_cell
      logic hold_left;
      logic fill_left;
      if (gi == 7) begin : g_msb
        assign hold_left = prev_data_reg;
        assign fill_left = prev_data_reg;
      end else begin : g_inner
        assign hold_left = hold_byte_reg[gi+1];
        assign fill_left = FILL_BYTE[gi+1];
      end
      assign hold_mfm_word[2*gi]   = hold_byte_reg[gi];
      assign hold_mfm_word[2*gi+1] = ~hold_left & ~hold_byte_reg[gi];
      assign fill_mfm_word[2*gi]   = FILL_BYTE[gi];
      assign fill_mfm_word[2*gi+1] = ~fill_left & ~FILL_BYTE[gi];
    end
  endgenerate

  // Sync marks are only substituted for the two recognised bytes; any other
  // byte flagged as sync is encoded normally.
  always_comb begin
    load_word = hold_mfm_word;
    if (hold_sync_reg && (hold_byte_reg == SYNC_A1_BYTE)) begin
      load_word = SYNC_A1_WORD;
    end else if (hold_sync_reg && (hold_byte_reg == SYNC_C2_BYTE)) begin
      load_word = SYNC_C2_WORD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_byte_reg <= 8'h00;
      hold_sync_reg <= 1'b0;
      hold_full_reg <= 1'b0;
      shift_reg     <= 16'h0000;
      cnt_reg       <= 4'd0;
      active_reg    <= 1'b0;
      prev_data_reg <= 1'b0;
      bit_out_reg   <= 1'b0;
      bit_valid_reg <= 1'b0;
      underrun_reg  <= 1'b0;
    end else if (!enable) begin
      // Abort: partial word is dropped, nothing is flushed.
      hold_full_reg <= 1'b0;
      shift_reg     <= 16'h0000;
      cnt_reg       <= 4'd0;
      active_reg    <= 1'b0;
      prev_data_reg <= 1'b0;
      bit_valid_reg <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      bit_valid_reg <= 1'b0;

      if (tick_en) begin
        if (cnt_reg != 4'd0) begin
          bit_out_reg   <= shift_reg[15];
          shift_reg     <= {shift_reg[14:0], 1'b0};
          cnt_reg       <= cnt_reg - 4'd1;
          bit_valid_reg <= 1'b1;
        end else if (hold_full_reg) begin
          // Load and emit the first cell on the same tick. For A1 and C2
          // the last data cell equals byte[0], so hold_byte_reg[0] is the
          // correct neighbour for the next word in every case.
          bit_out_reg   <= load_word[15];
          shift_reg     <= {load_word[14:0], 1'b0};
          cnt_reg       <= LAST_CELL;
          bit_valid_reg <= 1'b1;
          active_reg    <= 1'b1;
          prev_data_reg <= hold_byte_reg[0];
          hold_full_reg <= 1'b0;
        end else if (active_reg) begin
          bit_out_reg   <= fill_mfm_word[15];
          shift_reg     <= {fill_mfm_word[14:0], 1'b0};
          cnt_reg       <= LAST_CELL;
          bit_valid_reg <= 1'b1;
          prev_data_reg <= FILL_BYTE[0];
          underrun_reg  <= 1'b1;
        end
      end

      // A transfer takes priority over the clear from a load. A byte taken
      // on a boundary tick is not bypassed into the shifter: the tick above
      // already saw the register empty.
      if (transfer) begin
        hold_byte_reg <= byte_in;
        hold_sync_reg <= byte_sync;
        hold_full_reg <= 1'b1;
      end
    end
  end

  assign bit_out   = bit_out_reg;
  assign bit_valid = bit_valid_reg;
  assign underrun  = underrun_reg;
  assign busy      = active_reg | hold_full_reg;

endmodule

// File: tb/tb_mfm_encoder_sync.sv
module tb_mfm_encoder_sync;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] byte_in;
  logic       byte_sync;
  logic       byte_valid;
  logic       byte_ready;
  logic       bit_tick;
  logic       bit_out;
  logic       bit_valid;
  logic       busy;
  logic       underrun;

  int checks   = 0;
  int failures = 0;

  // Byte offered to the DUT while a word is shifting
  logic       pend;
  logic [7:0] pend_byte;
  logic       pend_sync;

  mfm_encoder_sync #(.FILL_BYTE(8'h4E)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .byte_in    (byte_in),
    .byte_sync  (byte_sync),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .bit_tick   (bit_tick),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for byte_ready, then present one byte for one cycle.
  task automatic put_byte(input logic [7:0] b, input logic s);
    int n;
    n = 0;
    while (!byte_ready && n < 50) begin
      step();
      n++;
    end
    if (!byte_ready) check("ready_timeout", 32'(byte_ready), 32'd1);
    byte_in    = b;
    byte_sync  = s;
    byte_valid = 1'b1;
    step();
    byte_valid = 1'b0;
  endtask

  // Sixteen back-to-back ticks; collect the cells MSB-first. A pending byte
  // is handed over as soon as the holding register is free.
  task automatic run_word(input logic [15:0] exp, input string tag);
    logic [15:0] w;
    int          nv;
    logic        took;
    w  = 16'h0000;
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      took = 1'b0;
      if (pend && byte_ready) begin
        byte_in    = pend_byte;
        byte_sync  = pend_sync;
        byte_valid = 1'b1;
        took       = 1'b1;
      end
      bit_tick = 1'b1;
      step();
      bit_tick   = 1'b0;
      byte_valid = 1'b0;
      if (took) pend = 1'b0;
      if (bit_valid) nv++;
      w = {w[14:0], bit_out};
    end
    check({tag, "_word"}, 32'(w), 32'(exp));
    check({tag, "_valid_count"}, 32'(nv), 32'd16);
  endtask

  task automatic offer(input logic [7:0] b, input logic s);
    pend      = 1'b1;
    pend_byte = b;
    pend_sync = s;
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    step();
    enable = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    byte_in    = 8'h00;
    byte_sync  = 1'b0;
    byte_valid = 1'b1;
    bit_tick   = 1'b1;
    pend       = 1'b0;
    pend_byte  = 8'h00;
    pend_sync  = 1'b0;

    // 1: reset state, ticks and valid ignored
    step();
    step();
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bit_out", 32'(bit_out), 32'd0);
    reset      = 1'b0;
    byte_valid = 1'b0;
    bit_tick   = 1'b0;
    step();

    // Idle tick with enable high: nothing emitted
    enable = 1'b1;
    bit_tick = 1'b1;
    step();
    bit_tick = 1'b0;
    check("idle_tick_valid", 32'(bit_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(byte_ready), 32'd1);

    // Byte and tick in the same cycle while idle: not bypassed
    byte_in    = 8'hFF;
    byte_sync  = 1'b0;
    byte_valid = 1'b1;
    bit_tick   = 1'b1;
    step();
    byte_valid = 1'b0;
    bit_tick   = 1'b0;
    check("same_cycle_valid", 32'(bit_valid), 32'd0);
    check("same_cycle_busy", 32'(busy), 32'd1);
    check("same_cycle_ready", 32'(byte_ready), 32'd0);
    run_word(16'h5555, "same_cycle_ff");

    // 2: 00 then FF
    drop_enable();
    put_byte(8'h00, 1'b0);
    offer(8'hFF, 1'b0);
    run_word(16'hAAAA, "t2_00");
    run_word(16'h5555, "t2_ff");
    check("t2_underrun", 32'(underrun), 32'd0);
    step();
    check("t2_no_tick_valid", 32'(bit_valid), 32'd0);

    // 3: A1 A1 A1 FE
    drop_enable();
    put_byte(8'hA1, 1'b1);
    offer(8'hA1, 1'b1);
    run_word(16'h4489, "t3_a1_0");
    offer(8'hA1, 1'b1);
    run_word(16'h4489, "t3_a1_1");
    offer(8'hFE, 1'b0);
    run_word(16'h4489, "t3_a1_2");
    run_word(16'h5554, "t3_fe");

    // 4: C2, 00, then 0x12 flagged sync (normal encode)
    drop_enable();
    put_byte(8'hC2, 1'b1);
    offer(8'h00, 1'b0);
    run_word(16'h5224, "t4_c2");
    offer(8'h12, 1'b1);
    run_word(16'hAAAA, "t4_00");
    run_word(16'hA924, "t4_12");
    check("t4_underrun", 32'(underrun), 32'd0);

    // 5: single 4E, then underflow fill
    drop_enable();
    put_byte(8'h4E, 1'b0);
    run_word(16'h9254, "t5_4e");
    check("t5_underrun_before", 32'(underrun), 32'd0);
    bit_tick = 1'b1;
    step();
    bit_tick = 1'b0;
    check("t5_underrun_at_load", 32'(underrun), 32'd1);
    check("t5_fill_first_cell", 32'(bit_out), 32'd1);
    // Remaining 15 fill cells
    for (int i = 0; i < 15; i++) begin
      bit_tick = 1'b1;
      step();
      bit_tick = 1'b0;
    end
    run_word(16'h9254, "t5_fill2");
    check("t5_busy", 32'(busy), 32'd1);

    // 6: abort mid-word, then restart
    drop_enable();
    put_byte(8'hFF, 1'b0);
    for (int i = 0; i < 7; i++) begin
      bit_tick = 1'b1;
      step();
    end
    enable = 1'b0;
    step();
    bit_tick = 1'b0;
    check("t6_abort_valid", 32'(bit_valid), 32'd0);
    check("t6_abort_busy", 32'(busy), 32'd0);
    check("t6_abort_underrun", 32'(underrun), 32'd0);
    enable = 1'b1;
    step();
    put_byte(8'h00, 1'b0);
    run_word(16'hAAAA, "t6_00");
    check("t6_underrun", 32'(underrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
